// File: rtl/l2req_arbiter_if.sv
// Request/response bundle between the three L2 requesters, the arbiter and the L2 port.
// master: arbiter side; slave: requesters, L2 and credit observers.
interface l2req_arbiter_if;
  typedef struct packed {
    logic        valid;
    logic [1:0]  core;
    logic [1:0]  unit;
    logic [1:0]  cmd;
    logic [31:0] addr;
  } l2req_packet_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  core;
    logic [1:0]  unit;
    logic [31:0] data;
  } l2rsp_packet_t;

  l2req_packet_t icache_l2req_packet;
  logic          icache_l2req_ready;
  l2req_packet_t dcache_l2req_packet;
  logic          dcache_l2req_ready;
  l2req_packet_t stbuf_l2req_packet;
  logic          stbuf_l2req_ready;
  l2req_packet_t l2req_packet;
  logic          l2req_ready;
  l2rsp_packet_t l2rsp_packet;
  logic [3:0]    outstanding_count;
  logic          idle;

  modport master (
    input  icache_l2req_packet, dcache_l2req_packet, stbuf_l2req_packet,
    input  l2req_ready, l2rsp_packet,
    output icache_l2req_ready, dcache_l2req_ready, stbuf_l2req_ready,
    output l2req_packet, outstanding_count, idle
  );

  modport slave (
    output icache_l2req_packet, dcache_l2req_packet, stbuf_l2req_packet,
    output l2req_ready, l2rsp_packet,
    input  icache_l2req_ready, dcache_l2req_ready, stbuf_l2req_ready,
    input  l2req_packet, outstanding_count, idle
  );
endinterface

// File: rtl/l2req_arbiter.sv
// Three-way L2 request arbiter with a one-entry output stage and per-core credit limit.
// L2REQ_ARB_FIXED_PRIORITY_EN selects fixed priority stbuf > dcache > icache instead of round-robin.
module l2req_arbiter #(
  parameter int CORE_ID         = 0,
  parameter int MAX_OUTSTANDING = 8
) (
  input logic             clk,
  input logic             reset,
  l2req_arbiter_if.master bus
);
  localparam logic [1:0] CORE    = 2'(CORE_ID);
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  logic [3:0] count;
  logic [2:0] req;
  logic [2:0] grant;
  logic       stage_free;
  logic       can_grant;
  logic       rsp_hit;
  logic       inc;
  logic       dec;

  assign req        = {bus.stbuf_l2req_packet.valid,
                       bus.dcache_l2req_packet.valid,
                       bus.icache_l2req_packet.valid};
  // The stage drains and refills on the same edge, so an accepted packet frees it now.
  assign stage_free = !bus.l2req_packet.valid || bus.l2req_ready;
  assign can_grant  = !reset && stage_free && (count < MAX_CNT);

`ifdef L2REQ_ARB_FIXED_PRIORITY_EN
  always_comb begin
    grant = 3'b000;
    if (can_grant) begin
      if (req[2])      grant = 3'b100;
      else if (req[1]) grant = 3'b010;
      else if (req[0]) grant = 3'b001;
    end
  end
`else
  logic [1:0] last;

  always_comb begin
    grant = 3'b000;
    if (can_grant) begin
      case (last)
        2'd0: begin
          if (req[1])      grant = 3'b010;
          else if (req[2]) grant = 3'b100;
          else if (req[0]) grant = 3'b001;
        end
        2'd1: begin
          if (req[2])      grant = 3'b100;
          else if (req[0]) grant = 3'b001;
          else if (req[1]) grant = 3'b010;
        end
        default: begin
          if (req[0])      grant = 3'b001;
          else if (req[1]) grant = 3'b010;
          else if (req[2]) grant = 3'b100;
        end
      endcase
    end
  end

  // Reset to stbuf so that icache is first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last <= 2'd2;
    end else if (grant[0]) begin
      last <= 2'd0;
    end else if (grant[1]) begin
      last <= 2'd1;
    end else if (grant[2]) begin
      last <= 2'd2;
    end
  end
`endif

  assign bus.icache_l2req_ready = grant[0];
  assign bus.dcache_l2req_ready = grant[1];
  assign bus.stbuf_l2req_ready  = grant[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.l2req_packet <= '0;
    end else if (|grant) begin
      if (grant[0])      bus.l2req_packet <= bus.icache_l2req_packet;
      else if (grant[1]) bus.l2req_packet <= bus.dcache_l2req_packet;
      else               bus.l2req_packet <= bus.stbuf_l2req_packet;
      bus.l2req_packet.valid <= 1'b1;
      bus.l2req_packet.core  <= CORE;
    end else if (stage_free) begin
      bus.l2req_packet.valid <= 1'b0;
    end
  end

  assign rsp_hit = bus.l2rsp_packet.valid && (bus.l2rsp_packet.core == CORE);
  assign inc     = |grant;
  assign dec     = rsp_hit && (count != 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else if (inc && !dec) begin
      count <= count + 4'd1;
    end else if (dec && !inc) begin
      count <= count - 4'd1;
    end
  end

  a_rsp_underflow: assert property (@(posedge clk) disable iff (reset) !(rsp_hit && count == 4'd0));

  assign bus.outstanding_count = count;
  assign bus.idle              = !bus.l2req_packet.valid && (count == 4'd0);

  logic unused_rsp;
  assign unused_rsp = ^{bus.l2rsp_packet.unit, bus.l2rsp_packet.data};
endmodule

// File: tb/tb_l2req_arbiter.sv
// Directed bench for l2req_arbiter: reset, grant order, credit limit, back-pressure, response filtering.
module tb_l2req_arbiter;
  localparam int CORE_ID = 1;
`ifdef L2REQ_ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l2req_arbiter_if bus ();

  l2req_arbiter #(.CORE_ID(CORE_ID), .MAX_OUTSTANDING(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [2:0] rdy();
    return {bus.stbuf_l2req_ready, bus.dcache_l2req_ready, bus.icache_l2req_ready};
  endfunction

  task automatic drive_req(input int idx, input logic v, input logic [31:0] addr);
    case (idx)
      0: begin
        bus.icache_l2req_packet.valid = v; bus.icache_l2req_packet.core = 2'd3;
        bus.icache_l2req_packet.unit = 2'd0; bus.icache_l2req_packet.cmd = 2'd1;
        bus.icache_l2req_packet.addr = addr;
      end
      1: begin
        bus.dcache_l2req_packet.valid = v; bus.dcache_l2req_packet.core = 2'd3;
        bus.dcache_l2req_packet.unit = 2'd1; bus.dcache_l2req_packet.cmd = 2'd2;
        bus.dcache_l2req_packet.addr = addr;
      end
      default: begin
        bus.stbuf_l2req_packet.valid = v; bus.stbuf_l2req_packet.core = 2'd3;
        bus.stbuf_l2req_packet.unit = 2'd2; bus.stbuf_l2req_packet.cmd = 2'd3;
        bus.stbuf_l2req_packet.addr = addr;
      end
    endcase
  endtask

  task automatic clear_inputs();
    bus.icache_l2req_packet = '0;
    bus.dcache_l2req_packet = '0;
    bus.stbuf_l2req_packet  = '0;
    bus.l2req_ready         = 1'b0;
    bus.l2rsp_packet        = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    drive_req(0, 1'b1, 32'h1);
    drive_req(1, 1'b1, 32'h2);
    drive_req(2, 1'b1, 32'h3);
    bus.l2req_ready = 1'b1;
    #1;
    n_cmp++; if (rdy() !== 3'b000) begin n_bad++; $display("FAIL reset_ready: got %b expected 000", rdy()); end
    @(negedge clk);
    n_cmp++; if (bus.l2req_packet !== '0) begin n_bad++; $display("FAIL reset_packet: got %h expected 0", bus.l2req_packet); end
    n_cmp++; if (bus.outstanding_count !== 4'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", bus.outstanding_count); end
    n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b expected 1", bus.idle); end
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [2:0] e_first, e_second;
    logic [1:0] u_first, u_second;
    e_first  = FIXED ? 3'b100 : 3'b001;
    e_second = FIXED ? 3'b001 : 3'b100;
    u_first  = FIXED ? 2'd2 : 2'd0;
    u_second = FIXED ? 2'd0 : 2'd2;
    do_reset();
    drive_req(0, 1'b1, 32'h100);
    drive_req(2, 1'b1, 32'h300);
    bus.l2req_ready = 1'b1;
    #1;
    n_cmp++; if (rdy() !== e_first) begin n_bad++; $display("FAIL rr_grant0: got %b expected %b", rdy(), e_first); end
    @(negedge clk);
    n_cmp++; if (bus.l2req_packet.valid !== 1'b1 || bus.l2req_packet.unit !== u_first) begin
      n_bad++; $display("FAIL rr_pkt1: got valid %b unit %0d expected valid 1 unit %0d", bus.l2req_packet.valid, bus.l2req_packet.unit, u_first); end
    n_cmp++; if (bus.l2req_packet.core !== 2'(CORE_ID)) begin n_bad++; $display("FAIL rr_core: got %0d expected %0d", bus.l2req_packet.core, CORE_ID); end
    drive_req(int'(u_first), 1'b0, 32'h0);
    #1;
    n_cmp++; if (rdy() !== e_second) begin n_bad++; $display("FAIL rr_grant1: got %b expected %b", rdy(), e_second); end
    @(negedge clk);
    n_cmp++; if (bus.l2req_packet.unit !== u_second || bus.l2req_packet.valid !== 1'b1) begin
      n_bad++; $display("FAIL rr_pkt2: got unit %0d expected %0d", bus.l2req_packet.unit, u_second); end
    n_cmp++; if (bus.l2req_packet.addr !== (FIXED ? 32'h100 : 32'h300)) begin
      n_bad++; $display("FAIL rr_addr2: got %h expected %h", bus.l2req_packet.addr, FIXED ? 32'h100 : 32'h300); end
    n_cmp++; if (bus.outstanding_count !== 4'd2) begin n_bad++; $display("FAIL rr_count: got %0d expected 2", bus.outstanding_count); end
    drive_req(int'(u_second), 1'b0, 32'h0);
    @(negedge clk);
    n_cmp++; if (bus.l2req_packet.valid !== 1'b0) begin n_bad++; $display("FAIL rr_drain: got valid %b expected 0", bus.l2req_packet.valid); end
    n_cmp++; if (bus.idle !== 1'b0) begin n_bad++; $display("FAIL rr_idle_busy: got %b expected 0", bus.idle); end
    bus.l2rsp_packet.valid = 1'b1;
    bus.l2rsp_packet.core  = 2'(CORE_ID);
    @(negedge clk);
    n_cmp++; if (bus.outstanding_count !== 4'd1) begin n_bad++; $display("FAIL rr_rsp1: got %0d expected 1", bus.outstanding_count); end
    @(negedge clk);
    bus.l2rsp_packet.valid = 1'b0;
    n_cmp++; if (bus.outstanding_count !== 4'd0) begin n_bad++; $display("FAIL rr_rsp2: got %0d expected 0", bus.outstanding_count); end
    n_cmp++; if (bus.idle !== 1'b1) begin n_bad++; $display("FAIL rr_idle: got %b expected 1", bus.idle); end
  endtask

  task automatic test_credits();
    logic [2:0] seq [8];
    if (FIXED) seq = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    else       seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    do_reset();
    drive_req(0, 1'b1, 32'h1000);
    drive_req(1, 1'b1, 32'h2000);
    drive_req(2, 1'b1, 32'h3000);
    bus.l2req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++; if (rdy() !== seq[i]) begin n_bad++; $display("FAIL credit_grant%0d: got %b expected %b", i, rdy(), seq[i]); end
      n_cmp++; if (bus.outstanding_count !== 4'(i)) begin n_bad++; $display("FAIL credit_count%0d: got %0d expected %0d", i, bus.outstanding_count, i); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (rdy() !== 3'b000) begin n_bad++; $display("FAIL credit_full_ready: got %b expected 000", rdy()); end
    n_cmp++; if (bus.outstanding_count !== 4'd8) begin n_bad++; $display("FAIL credit_full_count: got %0d expected 8", bus.outstanding_count); end
    @(negedge clk);
    n_cmp++; if (bus.l2req_packet.valid !== 1'b0) begin n_bad++; $display("FAIL credit_drain: got valid %b expected 0", bus.l2req_packet.valid); end
    bus.l2rsp_packet.valid = 1'b1;
    bus.l2rsp_packet.core  = 2'(CORE_ID);
    #1;
    n_cmp++; if (rdy() !== 3'b000) begin n_bad++; $display("FAIL credit_rsp_same_cycle: got %b expected 000", rdy()); end
    @(negedge clk);
    bus.l2rsp_packet.valid = 1'b0;
    n_cmp++; if (bus.outstanding_count !== 4'd7) begin n_bad++; $display("FAIL credit_freed: got %0d expected 7", bus.outstanding_count); end
    #1;
    n_cmp++; if (rdy() !== 3'b100) begin n_bad++; $display("FAIL credit_regrant: got %b expected 100", rdy()); end
    @(negedge clk);
    n_cmp++; if (bus.outstanding_count !== 4'd8) begin n_bad++; $display("FAIL credit_refull: got %0d expected 8", bus.outstanding_count); end
    n_cmp++; if (rdy() !== 3'b000) begin n_bad++; $display("FAIL credit_refull_ready: got %b expected 000", rdy()); end
  endtask

  task automatic test_backpressure();
    logic [$bits(bus.l2req_packet)-1:0] held;
    do_reset();
    bus.l2req_ready = 1'b0;
    drive_req(0, 1'b1, 32'hA0);
    #1;
    n_cmp++; if (rdy() !== 3'b001) begin n_bad++; $display("FAIL bp_first: got %b expected 001", rdy()); end
    @(negedge clk);
    drive_req(0, 1'b1, 32'hA4);
    drive_req(1, 1'b1, 32'hB0);
    held = bus.l2req_packet;
    n_cmp++; if (bus.l2req_packet.addr !== 32'hA0 || bus.l2req_packet.valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_loaded: got addr %h valid %b expected addr a0 valid 1", bus.l2req_packet.addr, bus.l2req_packet.valid); end
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (rdy() !== 3'b000) begin n_bad++; $display("FAIL bp_ready%0d: got %b expected 000", i, rdy()); end
      n_cmp++; if (bus.l2req_packet !== held) begin n_bad++; $display("FAIL bp_hold%0d: got %h expected %h", i, bus.l2req_packet, held); end
      @(negedge clk);
    end
    bus.l2req_ready = 1'b1;
    #1;
    n_cmp++; if (rdy() !== 3'b010) begin n_bad++; $display("FAIL bp_refill: got %b expected 010", rdy()); end
    @(negedge clk);
    n_cmp++; if (bus.l2req_packet.unit !== 2'd1 || bus.l2req_packet.addr !== 32'hB0) begin
      n_bad++; $display("FAIL bp_refill_pkt: got unit %0d addr %h expected unit 1 addr b0", bus.l2req_packet.unit, bus.l2req_packet.addr); end
    n_cmp++; if (bus.outstanding_count !== 4'd2) begin n_bad++; $display("FAIL bp_count: got %0d expected 2", bus.outstanding_count); end
  endtask

  task automatic test_rsp_filter();
    do_reset();
    bus.l2req_ready = 1'b1;
    drive_req(0, 1'b1, 32'h10);
    @(negedge clk);
    drive_req(0, 1'b0, 32'h0);
    n_cmp++; if (bus.outstanding_count !== 4'd1) begin n_bad++; $display("FAIL rsp_setup: got %0d expected 1", bus.outstanding_count); end
    bus.l2rsp_packet.valid = 1'b1;
    bus.l2rsp_packet.core  = 2'(CORE_ID + 1);
    @(negedge clk);
    n_cmp++; if (bus.outstanding_count !== 4'd1) begin n_bad++; $display("FAIL rsp_other_core: got %0d expected 1", bus.outstanding_count); end
    bus.l2rsp_packet.core = 2'(CORE_ID);
    drive_req(1, 1'b1, 32'h20);
    #1;
    n_cmp++; if (rdy() !== 3'b010) begin n_bad++; $display("FAIL rsp_same_grant: got %b expected 010", rdy()); end
    @(negedge clk);
    bus.l2rsp_packet.valid = 1'b0;
    drive_req(1, 1'b0, 32'h0);
    n_cmp++; if (bus.outstanding_count !== 4'd1) begin n_bad++; $display("FAIL rsp_grant_cancel: got %0d expected 1", bus.outstanding_count); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_credits();
    test_backpressure();
    test_rsp_filter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/l2req_arbiter.md
# l2req_arbiter

- Sits between the core's three L2 requesters and the single core-to-L2 request port.
- Requesters: instruction cache miss path, data cache load-miss path and store buffer.
- Picks one pending request per cycle, registers it in a one-entry output stage, and holds it until the L2 cache accepts it.
- Limits outstanding L2 transactions per core with a credit counter that is returned on L2 responses addressed to this core.

## Interface
Parameters:
- CORE_ID, 0, core number compared against l2rsp_packet.core for credit return.
- MAX_OUTSTANDING, 8, maximum accepted-but-unanswered requests (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- icache_l2req_packet  in  l2req_packet_t  icache request; .valid is the request.
- icache_l2req_ready  out  1  icache request granted this cycle.
- dcache_l2req_packet  in  l2req_packet_t  dcache load-miss request.
- dcache_l2req_ready  out  1  dcache request granted this cycle.
- stbuf_l2req_packet  in  l2req_packet_t  store buffer request.
- stbuf_l2req_ready  out  1  store buffer request granted this cycle.
- l2req_packet  out  l2req_packet_t  registered request to L2.
- l2req_ready  in  1  L2 accepts l2req_packet this cycle.
- l2rsp_packet  in  l2rsp_packet_t  L2 response broadcast.
- outstanding_count  out  4  current credits in use.
- idle  out  1  output stage empty and outstanding_count == 0.

## Operation
- Requester contract: once .valid is high, the packet holds stable until its ready is seen high on a clock edge. The arbiter never inspects a requester's fields before grant.
- The output stage is free this cycle when either condition holds:
  - l2req_packet.valid is 0, or
  - l2req_packet.valid && l2req_ready.
- A grant requires all of:
  - the output stage is free;
  - outstanding_count < MAX_OUTSTANDING;
  - at least one requester is valid.
- At most one *_ready is high per cycle. It is combinational from the inputs and state.
- On grant, the next edge loads the granted packet into l2req_packet with .valid = 1. The .core field is overwritten with CORE_ID; all other fields pass unchanged.
- Round-robin order is icache(0), dcache(1), stbuf(2). The last-granted index has lowest priority next cycle, and the pointer updates only on grant.
- When the output stage is free and nothing is granted, the next edge clears l2req_packet.valid.
- Credit counter:
  - increments on grant;
  - decrements when l2rsp_packet.valid && l2rsp_packet.core == CORE_ID;
  - is unchanged when both happen in the same cycle.
- A response that arrives when the count is 0 is an assertion failure; the counter saturates at 0.
- Responses are not otherwise touched; each unit filters l2rsp_packet itself.

## Timing
- Reset values:
  - l2req_packet all zero (valid 0);
  - all *_ready 0;
  - outstanding_count 0; idle 1;
  - round-robin pointer = stbuf, so icache wins first.
- Grant-to-L2 latency: 1 cycle (ready at cycle N, l2req_packet.valid at N+1).
- Throughput: one request per cycle while l2req_ready stays high and credits remain, because the drain and the refill happen on the same edge.
- Back-pressure: with l2req_ready low, l2req_packet stays bit-stable and no *_ready rises.
- Credits full: no grant, even if a response arrives the same cycle. The freed credit is usable the next cycle.
- Reset mid-operation discards a held output packet. Requesters reset together with this block.

## Configuration
- L2REQ_ARB_FIXED_PRIORITY_EN defined: fixed priority stbuf > dcache > icache; the round-robin pointer is removed.
- Not defined: round-robin as described in Operation.

## Test plan
- After reset, icache and stbuf both valid with l2req_ready=1:
  - icache_l2req_ready at cycle 0;
  - stbuf_l2req_ready at cycle 1;
  - l2req_packet.unit shows icache then stbuf at cycles 1 and 2.
- All three valid, l2req_ready=1, no responses, MAX_OUTSTANDING=8:
  - 8 grants in 8 consecutive cycles, in order I,D,S,I,D,S,I,D;
  - then no grant, with outstanding_count=8.
- With the count at 8, inject one response with core=CORE_ID: one grant follows on the next cycle, and the count returns to 8.
- Hold l2req_ready=0 for 5 cycles with a packet held in the output stage:
  - the packet stays unchanged and no *_ready rises;
  - raising l2req_ready gives a refill grant in that same cycle.
- A response with core=CORE_ID+1 leaves outstanding_count unchanged. A grant and a matching response in the same cycle also leave the count unchanged.
- With L2REQ_ARB_FIXED_PRIORITY_EN defined and all three valid, stbuf is granted on every cycle.
